// File: rtl/segment_real_mode_decompose.sv
// Splits a 32-bit linear address into a real-mode segment:offset pair over a two-stage valid/ready pipeline.
// Define SEGMENT_REAL_MODE_HMA_EN to allow results in the high memory area (0x100000..0x10FFEF).
module segment_real_mode_decompose (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] linear_address,
  input  logic        use_hint,
  input  logic [15:0] hint_segment,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] segment_value,
  output logic [15:0] offset,
  output logic        fault,
  output logic [7:0]  fault_count
);

`ifdef SEGMENT_REAL_MODE_HMA_EN
  localparam logic HMA_EN = 1'b1;
`else
  localparam logic HMA_EN = 1'b0;
`endif

  // Handshake: a beat moves on a rising edge when valid && ready; valid never waits on ready,
  // and ready never depends on valid. A stalled producer/consumer holds its payload unchanged.

  // Held low until the first edge after reset release so nothing is accepted during reset.
  logic        alive;

  logic        s1_valid;
  logic [31:0] s1_addr;
  logic        s1_use_hint;
  logic [15:0] s1_hint;

  logic        s1_advance;
  logic        out_fire;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = alive && (!s1_valid || s1_advance);
  assign out_fire   = out_valid && out_ready;

  // 33-bit difference: bit 32 set means the address lies below the hint base.
  logic [32:0] hint_diff;
  logic        addr_low;
  logic        addr_beyond;
  logic        reachable;
  logic        diff_in_window;
  logic [15:0] hma_offset;

  assign hint_diff      = {1'b0, s1_addr} - {13'd0, s1_hint, 4'h0};
  assign addr_low       = s1_addr < 32'h0010_0000;
  assign addr_beyond    = s1_addr >= 32'h0010_FFF0;
  assign reachable      = !addr_beyond && (addr_low || HMA_EN);
  assign diff_in_window = !hint_diff[32] && (hint_diff[31:16] == 16'd0);
  // addr - 0xFFFF0 modulo 2^16 equals addr[15:0] + 0x10.
  assign hma_offset     = s1_addr[15:0] + 16'h0010;

  logic        res_fault;
  logic [15:0] res_seg;
  logic [15:0] res_off;

  always_comb begin
    res_fault = 1'b1;
    res_seg   = 16'd0;
    res_off   = 16'd0;
    if (s1_use_hint) begin
      if (reachable && diff_in_window) begin
        res_fault = 1'b0;
        res_seg   = s1_hint;
        res_off   = hint_diff[15:0];
      end
    end else if (reachable) begin
      res_fault = 1'b0;
      if (addr_low) begin
        res_seg = s1_addr[19:4];
        res_off = {12'h000, s1_addr[3:0]};
      end else begin
        res_seg = 16'hFFFF;
        res_off = hma_offset;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive         <= 1'b0;
      s1_valid      <= 1'b0;
      s1_addr       <= 32'd0;
      s1_use_hint   <= 1'b0;
      s1_hint       <= 16'd0;
      out_valid     <= 1'b0;
      segment_value <= 16'd0;
      offset        <= 16'd0;
      fault         <= 1'b0;
      fault_count   <= 8'd0;
    end else begin
      alive <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_addr     <= linear_address;
          s1_use_hint <= use_hint;
          s1_hint     <= hint_segment;
        end
      end
      if (s1_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          segment_value <= res_seg;
          offset        <= res_off;
          fault         <= res_fault;
        end
      end
      if (out_fire && fault && (fault_count != 8'hFF)) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_segment_real_mode_decompose.sv
// Bench for segment_real_mode_decompose: directed cases plus randomized traffic against a behavioural model.
// Honours SEGMENT_REAL_MODE_HMA_EN the same way the design does.
module tb_segment_real_mode_decompose;

`ifdef SEGMENT_REAL_MODE_HMA_EN
  localparam bit HMA = 1'b1;
`else
  localparam bit HMA = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] linear_address = 32'd0;
  logic        use_hint = 1'b0;
  logic [15:0] hint_segment = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] segment_value;
  logic [15:0] offset;
  logic        fault;
  logic [7:0]  fault_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  int          exp_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [32:0] held = 33'd0;
  logic        acc;

  segment_real_mode_decompose dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .linear_address(linear_address), .use_hint(use_hint), .hint_segment(hint_segment),
    .out_valid(out_valid), .out_ready(out_ready),
    .segment_value(segment_value), .offset(offset),
    .fault(fault), .fault_count(fault_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a faulted result is {1, 32'h0}; otherwise {0, segment, offset}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic uh, input logic [15:0] h);
    longint la;
    longint d;
    longint top;
    logic [15:0] o;
    logic [15:0] s;
    la  = longint'(a);
    top = HMA ? 64'h10FFEF : 64'hFFFFF;
    if (la > top) return {1'b1, 32'h0};
    if (uh) begin
      d = la - longint'(h) * 16;
      if (d < 0 || d > 65535) return {1'b1, 32'h0};
      o = d[15:0];
      return {1'b0, h, o};
    end
    if (la < 64'h100000) begin
      s = 16'(la / 16);
      o = 16'(la % 16);
      return {1'b0, s, o};
    end
    d = la - 64'hFFFF0;
    o = d[15:0];
    return {1'b0, 16'hFFFF, o};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_cnt    = 0;
      stall_prev = 1'b0;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_fault_count", fault_count, 0);
    end else begin
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", {fault, segment_value, offset}, held);
      end
      check("fault_count", fault_count, exp_cnt);
      if (out_valid && out_ready) begin
        check("output_has_request", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("result", {fault, segment_value, offset}, e);
          if (e[32] && exp_cnt < 255) exp_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {fault, segment_value, offset};
      if (in_valid && in_ready) exp_q.push_back(model(linear_address, use_hint, hint_segment));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One request through an empty pipeline with out_ready=1; pins value and 2-cycle latency.
  task automatic run_one(input string name, input logic [31:0] a, input logic uh,
                         input logic [15:0] h, input logic [32:0] exp);
    out_ready      = 1'b1;
    linear_address = a;
    use_hint       = uh;
    hint_segment   = h;
    in_valid       = 1'b1;
    @(negedge clock);
    check({name, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 0);
    step();
    check({name, "_lat2_valid"}, out_valid, 1);
    check({name, "_result"}, {fault, segment_value, offset}, exp);
    step();
  endtask

  logic [31:0] edges[6] = '{32'hFFFFF, 32'h100000, 32'h10FFEF, 32'h10FFF0, 32'hFFFF0, 32'h0};

  task automatic rand_req();
    int sel;
    sel          = int'($urandom_range(0, 4));
    hint_segment = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFF));
    use_hint     = 1'($urandom_range(0, 1));
    case (sel)
      0: linear_address = 32'($urandom_range(0, 32'hFFFFF));
      1: linear_address = 32'h100000 + 32'($urandom_range(0, 32'hFFFF));
      2: linear_address = 32'($urandom);
      3: linear_address = {12'h000, hint_segment, 4'h0} + 32'($urandom_range(0, 32'h10800)) - 32'h400;
      default: linear_address = edges[$urandom_range(0, 5)];
    endcase
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] got[4];
  int idx;
  int nout;
  int sent;
  int seen;
  int guard;

  initial begin
    // model pins
    check("model_canon", model(32'h12345, 1'b0, 16'h0), {1'b0, 16'h1234, 16'h0005});
    check("model_hint_top", model(32'h1FFFF, 1'b1, 16'h1000), {1'b0, 16'h1000, 16'hFFFF});
    check("model_hint_over", model(32'h20000, 1'b1, 16'h1000), {1'b1, 32'h0});
    check("model_hint_under", model(32'h0FFFF, 1'b1, 16'h1000), {1'b1, 32'h0});
    check("model_hma", model(32'h10FFEF, 1'b0, 16'h0), HMA ? {1'b0, 16'hFFFF, 16'hFFFF} : {1'b1, 32'h0});

    #1 reset_n = 1'b0;
    repeat (3) step();
    check("rst_seg", segment_value, 0);
    check("rst_off", offset, 0);
    check("rst_fault", fault, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("in_ready_before_first_edge", in_ready, 0);
    step();
    check("in_ready_after_first_edge", in_ready, 1);

    run_one("canon_12345", 32'h12345, 1'b0, 16'h0000, {1'b0, 16'h1234, 16'h0005});
    run_one("hint_1ffff", 32'h1FFFF, 1'b1, 16'h1000, {1'b0, 16'h1000, 16'hFFFF});
    run_one("hint_20000", 32'h20000, 1'b1, 16'h1000, {1'b1, 32'h0});
    check("fault_count_one", fault_count, 1);
    run_one("hint_0ffff", 32'h0FFFF, 1'b1, 16'h1000, {1'b1, 32'h0});
    check("fault_count_two", fault_count, 2);
    run_one("hint_ffff_base", 32'hFFFF0, 1'b1, 16'hFFFF, {1'b0, 16'hFFFF, 16'h0000});
    run_one("canon_fffff", 32'hFFFFF, 1'b0, 16'h0000, {1'b0, 16'hFFFF, 16'h000F});
    run_one("addr_10fff0", 32'h10FFF0, 1'b0, 16'h0000, {1'b1, 32'h0});
    run_one("hint_10fff0", 32'h10FFF0, 1'b1, 16'hFFFF, {1'b1, 32'h0});
    if (HMA) begin
      run_one("hma_10ffef", 32'h10FFEF, 1'b0, 16'h0000, {1'b0, 16'hFFFF, 16'hFFFF});
      run_one("hma_100000", 32'h100000, 1'b0, 16'h0000, {1'b0, 16'hFFFF, 16'h0010});
      run_one("hma_hint_ffff", 32'h10FFEF, 1'b1, 16'hFFFF, {1'b0, 16'hFFFF, 16'hFFFF});
    end else begin
      run_one("nohma_100000", 32'h100000, 1'b0, 16'h0000, {1'b1, 32'h0});
      run_one("nohma_hint_ffff", 32'h10FFEF, 1'b1, 16'hFFFF, {1'b1, 32'h0});
    end

    // backpressure: four back-to-back requests against a stalled consumer
    out_ready = 1'b0;
    use_hint  = 1'b0;
    linear_address = 32'h10;
    in_valid  = 1'b1;
    idx  = 0;
    nout = 0;
    for (int c = 0; c < 30 && nout < 4; c++) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got[nout] = segment_value;
        nout++;
      end
      if (acc) idx++;
      if (c == 3) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", idx, 2);
      end
      step();
      if (acc) begin
        if (idx < 4) linear_address = 32'h10 * 32'(idx + 1);
        else in_valid = 1'b0;
      end
      if (c == 3) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_outputs_seen", nout, 4);
    for (int i = 0; i < 4; i++) check("bp_order", got[i], 16'(i + 1));

    // randomized traffic
    in_valid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      step();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_req();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    acc = in_valid && in_ready;
    step();
    if (acc) in_valid = 1'b0;
    while (in_valid) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    repeat (6) step();
    check("drain_queue_empty", exp_q.size(), 0);

    // saturation
    out_ready = 1'b1;
    linear_address = 32'hFFFF_FFFF;
    use_hint = 1'b0;
    in_valid = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 300 && guard < 1000) begin
      @(negedge clock);
      if (in_valid && in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("sat_sent", sent, 300);
    check("fault_count_saturated", fault_count, 8'hFF);

    // reset with two requests in flight
    out_ready = 1'b0;
    linear_address = 32'h500;
    in_valid = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 2 && guard < 20) begin
      @(negedge clock);
      if (in_valid && in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    check("inflight_sent", sent, 2);
    check("inflight_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_fault_count", fault_count, 0);
    check("async_rst_seg", segment_value, 0);
    step();
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen++;
      step();
    end
    check("no_stale_after_reset", seen, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_real_mode_decompose.md
SEGMENT_REAL_MODE_DECOMPOSE -- requirements
Module: segment_real_mode_decompose

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request offered.
REQ-005 in_ready  output  1  block can accept request this cycle.
REQ-006 linear_address  input  32  linear address to decompose.
REQ-007 use_hint  input  1  1: express address relative to hint_segment; 0: canonical normalization.
REQ-008 hint_segment  input  16  preferred segment value.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 segment_value  output  16  resulting segment.
REQ-012 offset  output  16  resulting offset.
REQ-013 fault  output  1  address not reachable as real-mode seg:off; segment_value and offset SHALL be 0 when set.
REQ-014 fault_count  output  8  saturating count of faulted results delivered.

Function
REQ-015 Transfer on an edge with in_valid&in_ready (input) or out_valid&out_ready (output).
REQ-016 Two registered stages, S1 captures inputs, S2 holds result; latency 2 cycles from input transfer to out_valid with no stall.
REQ-017 Full throughput of 1 request/cycle while out_ready=1.
REQ-018 in_ready = !S1.valid | S1 advancing; S1 advances when !S2.valid | out_ready. Combinational in_ready SHALL not depend on in_valid.
REQ-019 Results SHALL be delivered in request order; no loss or duplication under any backpressure pattern.
REQ-020 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 use_hint=0, linear_address < 0x100000: segment_value = linear_address[19:4], offset = {12'h000, linear_address[3:0]}, fault=0.
REQ-022 use_hint=1: diff = linear_address - {hint_segment,4'h0}, computed 33-bit; if 0 <= diff <= 0xFFFF, segment_value = hint_segment, offset = diff[15:0], fault=0; else fault=1.
REQ-023 use_hint=0, linear_address >= 0x100000: handled per REQ-030/031.
REQ-024 Hint arithmetic SHALL not wrap at 1 MB: hint 0xFFFF reaches 0xFFFF0..0x10FFEF only via the 33-bit difference, subject to REQ-030/031.
REQ-025 fault_count increments on each output transfer with fault=1, saturates at 0xFF, never wraps.

Reset
REQ-026 reset_n low SHALL immediately clear S1/S2 valid, out_valid=0, segment_value=0, offset=0, fault=0, fault_count=0.
REQ-027 During reset in_ready=0; in_ready=1 first edge after reset_n deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight requests; none delivered afterward.

Configuration
REQ-029 Macro SEGMENT_REAL_MODE_HMA_EN selects high-memory-area support.
REQ-030 Defined: use_hint=0 with 0x100000 <= linear_address <= 0x10FFEF yields segment_value=0xFFFF, offset = linear_address - 0xFFFF0, fault=0; use_hint=1 results above 0xFFFFF allowed per REQ-022.
REQ-031 Not defined: any linear_address >= 0x100000 SHALL fault regardless of use_hint.
REQ-032 Addresses >= 0x10FFF0 SHALL fault in both configurations.

Verification
REQ-033 linear 0x00012345, use_hint=0, out_ready=1 -> 2 cycles later segment 0x1234, offset 0x0005, fault 0.
REQ-034 use_hint=1, hint 0x1000: linear 0x1FFFF -> seg 0x1000 off 0xFFFF; linear 0x20000 -> fault 1, seg/off 0, fault_count 1; linear 0x0FFFF -> fault 1.
REQ-035 HMA_EN defined: linear 0x10FFEF -> seg 0xFFFF off 0xFFFF; 0x10FFF0 -> fault; undefined: 0x100000 -> fault.
REQ-036 Offer 0x10,0x20,0x30,0x40 back-to-back with out_ready=0 for 4 cycles -> in_ready low after 2 accepted; on release results seg 0x0001,0x0002,0x0003,0x0004 in order, outputs stable while stalled.
REQ-037 300 faulting requests -> fault_count saturates at 0xFF; reset_n pulse with 2 requests in flight -> out_valid 0, fault_count 0, no stale result delivered.
